// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcode values and FSM state encoding.
package alu_pkg;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_MUL  = 4'b0011;
   localparam logic [3:0] OP_DIV  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_LLS  = 4'b1000;
   localparam logic [3:0] OP_LRS  = 4'b1001;
   localparam logic [3:0] OP_INC  = 4'b1010;
   localparam logic [3:0] OP_DEC  = 4'b1011;
   localparam logic [3:0] OP_LAST = 4'b1011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

endpackage

// File: rtl/alu_op_check.sv
// Flags commands the ALU must never see: NOP, opcodes past OP_LAST, and divide by zero.
module alu_op_check
   import alu_pkg::*;
(
   input  logic [3:0]  opcode,
   input  logic [15:0] cmd_b,
   output logic        illegal
);

   assign illegal = (opcode == OP_NOP) || (opcode > OP_LAST) ||
                    ((opcode == OP_DIV) && (cmd_b == 16'd0));

endmodule

// File: rtl/alu_cmd_issuer.sv
// Accepts one ALU command at a time, holds it on the ALU inputs for the pipeline latency,
// then returns the captured result. Both sides use valid/ready: a transfer happens on a
// rising edge where valid and ready are both high; valid never depends on ready.
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int ALU_LATENCY = 2,
   parameter int TAG_W       = 4
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_opcode,
   input  logic [15:0]      cmd_a,
   input  logic [15:0]      cmd_b,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [15:0]      alu_operandA,
   output logic [15:0]      alu_operandB,
   output logic [3:0]       alu_opcode,
   input  logic [31:0]      alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_error,
   output logic             busy
);

   localparam int CNT_W = $clog2(ALU_LATENCY + 2);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       op_q;
   logic [15:0]      a_q, b_q;
   logic             illegal;
   logic             accept;
   logic             capture;

   alu_op_check u_op_check (
      .opcode  (cmd_opcode),
      .cmd_b   (cmd_b),
      .illegal (illegal)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      cmd_ready    = 1'b0;
      rsp_valid    = 1'b0;
      busy         = 1'b1;
      accept       = 1'b0;
      capture      = 1'b0;
      alu_opcode   = OP_NOP;
      alu_operandA = 16'd0;
      alu_operandB = 16'd0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               accept  = 1'b1;
               state_d = illegal ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            alu_opcode   = op_q;
            alu_operandA = a_q;
            alu_operandB = b_q;
            // Counter hits zero on the edge closing the last held cycle, when result is valid.
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         op_q       <= OP_NOP;
         a_q        <= 16'd0;
         b_q        <= 16'd0;
         rsp_result <= 32'd0;
         rsp_tag    <= '0;
         rsp_error  <= 1'b0;
      end else if (accept) begin
         op_q       <= cmd_opcode;
         a_q        <= cmd_a;
         b_q        <= cmd_b;
         rsp_tag    <= cmd_tag;
         cnt_q      <= CNT_W'(ALU_LATENCY);
         rsp_result <= 32'd0;
         rsp_error  <= illegal;
      end else if (capture) begin
         rsp_result <= alu_result;
         rsp_error  <= 1'b0;
      end else if ((state_q == ST_ISSUE) && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

endmodule
